// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, write-address layout, streamer states and the
// row/column to linear-index mapping.
package fb_pkg;

  localparam int unsigned FB_COLS   = 80;
  localparam int unsigned FB_ROWS   = 60;
  localparam int unsigned FB_PIXELS = FB_COLS * FB_ROWS;
  localparam int unsigned IDX_W     = 13;
  localparam int unsigned ROW_W     = 6;
  localparam int unsigned COL_W     = 7;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } fb_addr_t;

  typedef enum logic [1:0] {
    GAP = 2'd0,
    CMD = 2'd1,
    PIX = 2'd2
  } spi_state_t;

  function automatic logic [IDX_W-1:0] rc_to_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(FB_COLS) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/fb_spi_streamer_80x60_if.sv
// Pixel-write bus from the text driver plus the SPI pins toward the display.
// master = driver side, slave = streamer side.
interface fb_spi_streamer_80x60_if;
  import fb_pkg::*;

  fb_addr_t   wa;
  logic [7:0] wd;
  logic       we;
  logic       en;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       dc;
  logic       frame_done;
  logic       busy;

  modport master (
    output wa, wd, we, en,
    input  sclk, mosi, cs_n, dc, frame_done, busy
  );

  modport slave (
    input  wa, wd, we, en,
    output sclk, mosi, cs_n, dc, frame_done, busy
  );

endinterface

// File: rtl/fb_ram_4800x8_dp.sv
// 4800x8 simple dual-port RAM: one write port, one synchronous read port,
// read-first on a same-address collision. No reset, maps onto block RAM.
module fb_ram_4800x8_dp
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [FB_PIXELS];

  // Both ports in one block so a colliding read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_spi_streamer_80x60.sv
// 80x60 framebuffer that accepts pixel writes and continuously streams the
// whole frame (command byte + 4800 pixels) over a mode-0 write-only SPI link.
module fb_spi_streamer_80x60
  import fb_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FRAME_GAP = 64,
  parameter logic [7:0]  CMD_BYTE  = 8'h2C
) (
  input logic                    CLK_50MHz,
  input logic                    RESET,
  fb_spi_streamer_80x60_if.slave bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = $clog2(FRAME_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB_PIXELS - 1);

  spi_state_t       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [IDX_W-1:0] pix_idx;
  logic [7:0]       shifter;
  logic             fetch_req;
  logic [IDX_W-1:0] fetch_idx;
  logic [7:0]       rd_data;

  logic sclk;
  logic mosi;
  logic cs_n;
  logic dc;
  logic frame_done;
  logic busy;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  // Out-of-range rows/cols are dropped before they can alias another pixel.
  always_comb begin
    wr_en  = bus.we && (bus.wa.row < ROW_W'(FB_ROWS)) && (bus.wa.col < COL_W'(FB_COLS));
    wr_idx = rc_to_index(bus.wa.row, bus.wa.col);
  end

  fb_ram_4800x8_dp u_ram (
    .clk   (CLK_50MHz),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (bus.wd),
    .re    (fetch_req),
    .raddr (fetch_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK_50MHz) begin
    if (!RESET) begin
      state      <= GAP;
      gap_cnt    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      pix_idx    <= '0;
      shifter    <= '0;
      fetch_req  <= 1'b0;
      fetch_idx  <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      dc         <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      fetch_req  <= 1'b0;
      unique case (state)
        GAP: begin
          // Counter parks at its terminal value while EN is low.
          if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
            if (bus.en) begin
              state     <= CMD;
              cs_n      <= 1'b0;
              busy      <= 1'b1;
              dc        <= 1'b0;
              sclk      <= 1'b0;
              mosi      <= CMD_BYTE[7];
              shifter   <= CMD_BYTE;
              bit_cnt   <= '0;
              div_cnt   <= '0;
              pix_idx   <= '0;
              fetch_idx <= '0;
              fetch_req <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        CMD, PIX: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: the only place MOSI, DC and the shifter move.
              sclk <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                shifter <= {shifter[6:0], 1'b0};
                mosi    <= shifter[6];
              end else begin
                bit_cnt <= '0;
                if (state == PIX && pix_idx == LAST_IDX) begin
                  state      <= GAP;
                  gap_cnt    <= '0;
                  cs_n       <= 1'b1;
                  busy       <= 1'b0;
                  dc         <= 1'b0;
                  mosi       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  shifter <= rd_data;
                  mosi    <= rd_data[7];
                  dc      <= 1'b1;
                  if (state == CMD) begin
                    state     <= PIX;
                    pix_idx   <= '0;
                    fetch_idx <= IDX_W'(1);
                    fetch_req <= 1'b1;
                  end else begin
                    pix_idx   <= pix_idx + IDX_W'(1);
                    fetch_idx <= pix_idx + IDX_W'(2);
                    fetch_req <= (pix_idx < IDX_W'(FB_PIXELS - 2));
                  end
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= GAP;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sclk       = sclk;
  assign bus.mosi       = mosi;
  assign bus.cs_n       = cs_n;
  assign bus.dc         = dc;
  assign bus.frame_done = frame_done;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_fb_spi_streamer_80x60.sv
// Directed bench for the 80x60 SPI frame streamer: decodes the SPI stream
// bit by bit and checks framing, timing and pixel contents.
`timescale 1ns/1ps
module tb_fb_spi_streamer_80x60;
  import fb_pkg::*;

  localparam int DIV     = 1;
  localparam int GAP_LEN = 64;
  localparam int BP      = 16 * DIV;
  localparam int NBYTES  = FB_PIXELS + 1;
  localparam int E0      = GAP_LEN;

  logic clk = 1'b0;
  logic rst_n;

  fb_spi_streamer_80x60_if bus();

  fb_spi_streamer_80x60 #(
    .CLK_DIV   (DIV),
    .FRAME_GAP (GAP_LEN),
    .CMD_BYTE  (8'h2C)
  ) dut (
    .CLK_50MHz (clk),
    .RESET     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc, low_cyc, fd_cnt, per_viol, mosi_viol, dc_viol, last_rise, ncap, nbits;
  logic [7:0] shreg;
  logic cur_dc, prev_sclk, prev_mosi, prev_dc;
  logic [7:0] cap   [NBYTES];
  logic       capdc [NBYTES];

  function automatic void clear_capture();
    cyc = 0; low_cyc = 0; fd_cnt = 0; per_viol = 0; mosi_viol = 0; dc_viol = 0;
    last_rise = -1; ncap = 0; nbits = 0; shreg = 8'h00; cur_dc = 1'b0;
    prev_sclk = 1'b0; prev_mosi = 1'b0; prev_dc = 1'b0;
  endfunction

  // One clock, then sample outputs 1ns later and decode the SPI stream.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cs_n === 1'b0) begin
      low_cyc++;
      if (bus.sclk === 1'b1 && bus.mosi !== prev_mosi) mosi_viol++;
      if (bus.sclk === 1'b1 && bus.dc !== prev_dc) dc_viol++;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (last_rise >= 0 && (cyc - last_rise) != 2 * DIV) per_viol++;
        last_rise = cyc;
        shreg = {shreg[6:0], bus.mosi};
        if (nbits == 0) cur_dc = bus.dc;
        else if (bus.dc !== cur_dc) dc_viol++;
        nbits++;
        if (nbits == 8) begin
          if (ncap < NBYTES) begin
            cap[ncap]   = shreg;
            capdc[ncap] = cur_dc;
          end
          ncap++;
          nbits = 0;
        end
      end
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
    prev_sclk = bus.sclk;
    prev_mosi = bus.mosi;
    prev_dc   = bus.dc;
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d);
    bus.wa.row = 6'(r);
    bus.wa.col = 7'(c);
    bus.wd     = d;
    bus.we     = 1'b1;
    step();
    bus.we     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.we = 1'b0; bus.wa = '0; bus.wd = 8'h00;
    clear_capture();
    repeat (3) step();
    total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", bus.sclk); end
    total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", bus.mosi); end
    total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", bus.cs_n); end
    total++; if (bus.dc !== 1'b0) begin bad++; $display("FAIL rst_dc: got %b want 0", bus.dc); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", bus.frame_done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
  endtask

  // Fill everything dark, light two corners, then fire out-of-range writes.
  task automatic fill_frame();
    rst_n = 1'b1;
    clear_capture();
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) wr(r, c, 8'hFF);
    end
    wr(0, 0, 8'h00);
    wr(59, 79, 8'h00);
    wr(60, 5, 8'h00);
    wr(3, 80, 8'h00);
    wr(63, 127, 8'h00);
    step();
    total++; if (low_cyc != 0) begin bad++; $display("FAIL idle_cs_n: got %0d low cycles want 0", low_cyc); end
  endtask

  task automatic test_frame_start();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1; bus.en = 1'b1;
    clear_capture();
    repeat (GAP_LEN - 1) step();
    total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL cs_n_before_gap_end: got %b want 1", bus.cs_n); end
    step();
    total++; if (bus.cs_n !== 1'b0) begin bad++; $display("FAIL cs_n_fall_at_gap: got %b want 0", bus.cs_n); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_at_cmd: got %b want 1", bus.busy); end
    total++; if (bus.dc !== 1'b0) begin bad++; $display("FAIL dc_at_cmd: got %b want 0", bus.dc); end
    total++; if (bus.sclk !== 1'b0 || bus.mosi !== 1'b0) begin bad++;
      $display("FAIL first_bit: got sclk=%b mosi=%b want sclk=0 mosi=0", bus.sclk, bus.mosi); end
    repeat (DIV) step();
    total++; if (bus.sclk !== 1'b1) begin bad++; $display("FAIL first_rise: got %b want 1", bus.sclk); end
  endtask

  // Pixel 100 written on its fetch edge (stays dark), pixel 200 one edge earlier (lit).
  task automatic test_fetch_collision();
    while (cyc < E0 + 100 * BP) step();
    bus.wa.row = 6'd1; bus.wa.col = 7'd20; bus.wd = 8'h00; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
    while (cyc < E0 + 200 * BP - 1) step();
    bus.wa.row = 6'd2; bus.wa.col = 7'd40; bus.wd = 8'h00; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_mid_frame: got %b want 1", bus.busy); end
  endtask

  task automatic test_en_drop();
    int guard;
    int oth;
    int dcbad;
    logic fd_end;
    while (cyc < E0 + 2001 * BP + 5) step();
    bus.en = 1'b0;
    guard = 0;
    while (bus.cs_n === 1'b0 && guard < NBYTES * BP + 16) begin step(); guard++; end
    fd_end = bus.frame_done;
    total++; if (ncap != NBYTES) begin bad++; $display("FAIL frame_bytes: got %0d want %0d", ncap, NBYTES); end
    total++; if (low_cyc != NBYTES * BP) begin bad++; $display("FAIL cs_n_low_cycles: got %0d want %0d", low_cyc, NBYTES * BP); end
    total++; if (fd_end !== 1'b1) begin bad++; $display("FAIL frame_done_at_end: got %b want 1", fd_end); end
    total++; if (cap[0] !== 8'h2C) begin bad++; $display("FAIL cmd_byte: got %h want 2c", cap[0]); end
    total++; if (capdc[0] !== 1'b0) begin bad++; $display("FAIL cmd_dc: got %b want 0", capdc[0]); end
    total++; if (cap[1] !== 8'h00) begin bad++; $display("FAIL pix0: got %h want 00", cap[1]); end
    total++; if (cap[NBYTES-1] !== 8'h00) begin bad++; $display("FAIL pix4799: got %h want 00", cap[NBYTES-1]); end
    total++; if (cap[101] !== 8'hFF) begin bad++; $display("FAIL pix100_same_cycle: got %h want ff", cap[101]); end
    total++; if (cap[201] !== 8'h00) begin bad++; $display("FAIL pix200_early: got %h want 00", cap[201]); end
    total++; if (cap[321] !== 8'hFF) begin bad++; $display("FAIL pix320_col80_dropped: got %h want ff", cap[321]); end
    oth = 0; dcbad = 0;
    for (int i = 1; i < NBYTES; i++) begin
      if (capdc[i] !== 1'b1) dcbad++;
      if (i != 1 && i != 201 && i != NBYTES - 1 && cap[i] !== 8'hFF) oth++;
    end
    total++; if (oth != 0) begin bad++; $display("FAIL other_pixels: got %0d non-ff bytes want 0", oth); end
    total++; if (dcbad != 0) begin bad++; $display("FAIL pixel_dc: got %0d bytes with dc=0 want 0", dcbad); end
    total++; if (per_viol != 0) begin bad++; $display("FAIL sclk_period: got %0d violations want 0", per_viol); end
    total++; if (mosi_viol != 0) begin bad++; $display("FAIL mosi_stable_high: got %0d violations want 0", mosi_viol); end
    total++; if (dc_viol != 0) begin bad++; $display("FAIL dc_stable: got %0d violations want 0", dc_viol); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_after_frame: got %b want 0", bus.busy); end
    step();
    total++; if (bus.frame_done !== 1'b0 || fd_cnt != 1) begin bad++;
      $display("FAIL frame_done_pulse: got level=%b count=%0d want 0 and 1", bus.frame_done, fd_cnt); end
  endtask

  task automatic test_idle_gap();
    clear_capture();
    repeat (300) step();
    total++; if (low_cyc != 0) begin bad++; $display("FAIL en_low_idle: got %0d low cycles want 0", low_cyc); end
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL en_low_frame_done: got %0d pulses want 0", fd_cnt); end
  endtask

  task automatic test_en_restart();
    int w;
    int guard;
    clear_capture();
    bus.en = 1'b1;
    w = 0;
    while (bus.cs_n !== 1'b0 && w < 200) begin step(); w++; end
    total++; if (w != 1) begin bad++; $display("FAIL restart_wait: got %0d cycles want 1", w); end
    guard = 0;
    while (ncap < 102 && guard < 102 * BP + 50) begin step(); guard++; end
    total++; if (cap[0] !== 8'h2C || capdc[0] !== 1'b0) begin bad++;
      $display("FAIL restart_cmd: got %h dc=%b want 2c dc=0", cap[0], capdc[0]); end
    total++; if (cap[2] !== 8'hFF) begin bad++; $display("FAIL restart_pix1: got %h want ff", cap[2]); end
    total++; if (cap[101] !== 8'h00 || capdc[101] !== 1'b1) begin bad++;
      $display("FAIL next_frame_pix100: got %h dc=%b want 00 dc=1", cap[101], capdc[101]); end
  endtask

  task automatic test_reset_mid();
    int w;
    int guard;
    repeat (5) step();
    total++; if (bus.busy !== 1'b1 || bus.dc !== 1'b1) begin bad++;
      $display("FAIL pre_reset_pix: got busy=%b dc=%b want 1 1", bus.busy, bus.dc); end
    rst_n = 1'b0;
    step();
    total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL abort_cs_n: got %b want 1", bus.cs_n); end
    total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk: got %b want 0", bus.sclk); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    total++; if (bus.mosi !== 1'b0 || bus.dc !== 1'b0) begin bad++;
      $display("FAIL abort_mosi_dc: got mosi=%b dc=%b want 0 0", bus.mosi, bus.dc); end
    step();
    rst_n = 1'b1;
    clear_capture();
    w = 0;
    while (bus.cs_n !== 1'b0 && w < 200) begin step(); w++; end
    total++; if (w != GAP_LEN) begin bad++; $display("FAIL post_reset_wait: got %0d cycles want %0d", w, GAP_LEN); end
    guard = 0;
    while (ncap < 202 && guard < 202 * BP + 50) begin step(); guard++; end
    total++; if (cap[0] !== 8'h2C) begin bad++; $display("FAIL post_reset_cmd: got %h want 2c", cap[0]); end
    total++; if (cap[1] !== 8'h00) begin bad++; $display("FAIL retained_pix0: got %h want 00", cap[1]); end
    total++; if (cap[101] !== 8'h00) begin bad++; $display("FAIL retained_pix100: got %h want 00", cap[101]); end
    total++; if (cap[201] !== 8'h00) begin bad++; $display("FAIL retained_pix200: got %h want 00", cap[201]); end
    total++; if (cap[150] !== 8'hFF) begin bad++; $display("FAIL retained_pix149: got %h want ff", cap[150]); end
  endtask

  initial begin
    test_reset();
    fill_frame();
    test_frame_start();
    test_fetch_collision();
    test_en_drop();
    test_idle_gap();
    test_en_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
